chan_mesh_top: RTL and testbench
================================

Name: chan_mesh_top

Overview:
- Parametrised successor to the fixed 3-in/2-out trivial netlist.
- Accepts CH independent input channels of W bits each, with valid/ready handshake, and passes each through a DEPTH-stage registered pipeline.
- Optional per-channel feedback accumulation closes the loop locally in each channel.
- A round-robin merge stage drives one registered output stream plus a transfer counter.
- Used as the sequential, multi-instance test design for schematic/connectivity views.

Parameters:
- CH, 3, number of input channels (2..8).
- W, 8, data width per channel (1..32).
- DEPTH, 2, register stages per channel pipeline (1..4).
- ACC_MASK, 0, CH-bit mask; bit i set puts channel i in accumulate mode.
- CNT_W, 16, width of the output transfer counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  CH*W  channel i occupies bits [i*W +: W].
- in_valid  in  CH  per-channel valid.
- in_ready  out  CH  per-channel ready.
- out_data  out  W  merged output word.
- out_chan  out  CHW  source channel of out_data; CHW = max(1, clog2(CH)).
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_count  out  CNT_W  number of completed output transfers.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset contents: rst_n low immediately clears every stage valid, all accumulators, out_valid, out_data, out_chan and out_count to 0, and sets the arbiter last-grant pointer to CH-1.
- No reset mid-operation preserves data; in-flight words are dropped.
- Reset-time ready: in_ready is all 1s during and after reset, because the pipelines are empty.
- Transfer definition: a transfer occurs on any cycle where valid && ready are both high.
- Channel pipeline:
  - Stage k (0..DEPTH-1) holds {valid, data}.
  - Stage k advances when it is empty, or when its content moves on (stage k+1 advances, or for the last stage, it is granted by the arbiter).
  - in_ready[i] = stage 0 of channel i advances.
  - Throughput is 1 word/cycle/channel when uncontested and unstalled.
  - Capacity is DEPTH words per channel.
- Accumulate mode (ACC_MASK[i]=1):
  - The word presented to the arbiter is acc[i] + head_data, mod 2^W (carry discarded).
  - On grant, acc[i] takes that sum.
  - Channels with the mask bit clear pass data unchanged.
- Arbiter:
  - Candidates are channels whose last stage is valid.
  - The search starts at (last_grant+1) mod CH and takes the first candidate found.
  - At most one grant per cycle; last_grant updates only on a grant.
  - A grant happens only when the output register is empty or out_ready is high.
- Output register:
  - Loads {data, chan} on grant and sets out_valid.
  - Clears out_valid on a transfer with no new grant.
  - out_data and out_chan stay stable while out_valid && !out_ready.
- Latency:
  - Input transfer to out_valid is DEPTH+1 cycles with no contention or backpressure.
  - Under full contention each channel is served once every CH cycles.
- out_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - A grant and an output transfer in the same cycle keep out_valid high with the new word.
  - A channel whose last stage is granted while a new word enters stage 0 in the same cycle loses no data and duplicates none.
- Boundary behaviour:
  - CH=2 gives CHW=1.
  - DEPTH=1 gives a single stage feeding the arbiter directly.
  - in_data is ignored while in_valid is low.

Test Plan:
- Reset check: CH=3, W=8, DEPTH=2; pulse rst_n low between clock edges -> outputs are 0 within the same cycle, in_ready=3'b111, out_count=0.
- Single-word latency: cycle 0, ch0 sends 0x5A, out_ready=1 -> out_valid at cycle 3 with out_data=0x5A, out_chan=0; out_count=1 at cycle 4.
- Fair arbitration: ch0/1/2 send 0x11/0x22/0x33 in the same cycle -> three consecutive outputs, chan 0,1,2 with data 0x11, 0x22, 0x33; a second simultaneous burst is served again in order 0,1,2.
- Backpressure: out_ready=0, ch0 driven continuously -> exactly 3 words accepted (DEPTH + output register), then in_ready[0]=0; out_data is held. Raising out_ready drains the words in order with no loss.
- Accumulate mode: ACC_MASK=3'b100, ch2 sends 0xF0 then 0x20 -> outputs 0xF0 then 0x10 (wrap); ch0 sends 0x20 -> output 0x20, unchanged.
- Reset mid-stream: rst_n low with 2 words in flight and out_valid=1 -> out_valid=0 immediately; after release, no output appears until new input arrives and the accumulator restarts from 0; counter wrap checked with CNT_W=4 (16 transfers -> out_count=0).

Source files
------------

// File: rtl/chan_mesh_top.sv
`default_nettype none
// ============================================================================
// chan_mesh_top : CH valid/ready channels, DEPTH-stage pipelines, optional
//                 per-channel accumulation, round-robin merge to one stream.
// Revision 1.0
// ============================================================================
module chan_mesh_top #(
  parameter int              CH       = 3,
  parameter int              W        = 8,
  parameter int              DEPTH    = 2,
  parameter logic [CH-1:0]   ACC_MASK = '0,
  parameter int              CNT_W    = 16,
  localparam int             CHW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*W-1:0]     in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
  output logic [W-1:0]        out_data,
  output logic [CHW-1:0]      out_chan,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    out_count
);

  localparam logic [CHW:0] CH_N = CH[CHW:0];

  logic [CH-1:0]    cand;
  logic [CH-1:0]    grant;
  logic [W-1:0]     head [CH];
  logic             gnt_any;
  logic [CHW-1:0]   gnt_idx;
  logic [CHW:0]     arb_idx;
  logic             out_load;

  logic [CHW-1:0]   last_q;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic [CHW-1:0]   out_chan_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign out_load = !out_valid_q || out_ready;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];
    logic [DEPTH-1:0] adv;

    // A stage can move when any stage at or beyond it has a hole, or the head leaves.
    always_comb begin
      adv = '0;
      for (int k = 0; k < DEPTH; k++) begin
        adv[k] = grant[i];
        for (int j = k; j < DEPTH; j++) begin
          if (!vld_q[j]) adv[k] = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
      end else begin
        if (adv[0]) begin
          vld_q[0] <= in_valid[i];
          if (in_valid[i]) dat_q[0] <= in_data[i*W +: W];
        end
        for (int k = 1; k < DEPTH; k++) begin
          if (adv[k]) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
          end
        end
      end
    end

    if (ACC_MASK[i]) begin : g_acc
      logic [W-1:0] acc_q;
      logic [W-1:0] acc_d;
      assign acc_d   = acc_q + dat_q[DEPTH-1];
      assign head[i] = acc_d;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc_q <= '0;
        else if (grant[i]) acc_q <= acc_d;
      end
    end else begin : g_pass
      assign head[i] = dat_q[DEPTH-1];
    end

    assign cand[i]     = vld_q[DEPTH-1];
    assign in_ready[i] = adv[0];
    assign grant[i]    = gnt_any && (gnt_idx == CHW'(i));
  end

  // Round-robin search starting one past the previous winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    arb_idx = '0;
    for (int off = 1; off <= CH; off++) begin
      arb_idx = {1'b0, last_q} + off[CHW:0];
      if (arb_idx >= CH_N) arb_idx = arb_idx - CH_N;
      if (out_load && !gnt_any && cand[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_idx[CHW-1:0];
      end
    end
  end

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= CHW'(CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (gnt_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= head[gnt_idx];
        out_chan_q  <= gnt_idx;
        last_q      <= gnt_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && out_ready) cnt_q <= cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign out_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_chan_mesh_top.sv
`default_nettype none
// ============================================================================
// tb_chan_mesh_top : directed bench for chan_mesh_top (CH=3, W=8, DEPTH=2,
//                    channel 2 accumulating, 4-bit transfer counter).
// Revision 1.0
// ============================================================================
module tb_chan_mesh_top;

  localparam int CH    = 3;
  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CHW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*W-1:0]   in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [W-1:0]      out_data;
  logic [CHW-1:0]    out_chan;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chan_mesh_top #(
    .CH(CH), .W(W), .DEPTH(DEPTH), .ACC_MASK(3'b100), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic out_is(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({tag, ".data"}, 32'(out_data), 32'(d));
      chk({tag, ".chan"}, 32'(out_chan), 32'(c));
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_d;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;

    step(); #1;
    out_is("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.data", 32'(out_data), 32'h0);
    chk("rst.chan", 32'(out_chan), 32'h0);
    chk("rst.count", 32'(out_count), 32'h0);
    chk("rst.in_ready", 32'(in_ready), 32'h7);
    step(); rst_n = 1'b1;

    // Fair arbitration: two simultaneous bursts, ch2 accumulates (0x33, then 0x33+0x66).
    step(); in_valid = 3'b111; in_data = {8'h33, 8'h22, 8'h11}; #1;
    chk("fair.in_ready", 32'(in_ready), 32'h7);
    step(); in_valid = 3'b000; in_data = 24'hA5A5A5; #1;
    out_is("fair.c1", 1'b0, 8'h00, 2'd0);
    step(); #1;
    step(); #1; out_is("fair.c3", 1'b1, 8'h11, 2'd0);
    step(); #1; out_is("fair.c4", 1'b1, 8'h22, 2'd1);
    step(); #1; out_is("fair.c5", 1'b1, 8'h33, 2'd2);
    step(); in_valid = 3'b111; in_data = {8'h66, 8'h55, 8'h44}; #1;
    out_is("fair.c6", 1'b0, 8'h00, 2'd0);
    chk("fair.count3", 32'(out_count), 32'd3);
    step(); in_valid = 3'b000; #1;
    step(); #1;
    step(); #1; out_is("fair2.c3", 1'b1, 8'h44, 2'd0);
    step(); #1; out_is("fair2.c4", 1'b1, 8'h55, 2'd1);
    step(); #1; out_is("fair2.c5", 1'b1, 8'h99, 2'd2);

    // Single word latency: driven here, visible three cycles later.
    step(); in_valid = 3'b001; in_data = {8'h00, 8'h00, 8'h5A}; #1;
    out_is("fair2.c6", 1'b0, 8'h00, 2'd0);
    chk("fair2.count6", 32'(out_count), 32'd6);
    chk("single.in_ready", 32'(in_ready), 32'h7);
    step(); in_valid = 3'b000; #1; out_is("single.c1", 1'b0, 8'h00, 2'd0);
    step(); #1; out_is("single.c2", 1'b0, 8'h00, 2'd0);
    step(); #1; out_is("single.c3", 1'b1, 8'h5A, 2'd0);
    chk("single.count_c3", 32'(out_count), 32'd6);

    // Backpressure: three words fit (two stages plus the output register).
    step(); out_ready = 1'b0; in_valid = 3'b001; in_data = {16'h0, 8'hA1}; #1;
    out_is("single.c4", 1'b0, 8'h00, 2'd0);
    chk("single.count_c4", 32'(out_count), 32'd7);
    chk("bp.rdy0", 32'(in_ready[0]), 32'd1);
    step(); in_data = {16'h0, 8'hA2}; #1; chk("bp.rdy1", 32'(in_ready[0]), 32'd1);
    step(); in_data = {16'h0, 8'hA3}; #1; chk("bp.rdy2", 32'(in_ready[0]), 32'd1);
    step(); in_data = {16'h0, 8'hA4}; #1;
    chk("bp.rdy3", 32'(in_ready[0]), 32'd0);
    out_is("bp.hold3", 1'b1, 8'hA1, 2'd0);
    step(); #1;
    chk("bp.rdy4", 32'(in_ready[0]), 32'd0);
    chk("bp.other_rdy", 32'(in_ready[2:1]), 32'h3);
    out_is("bp.hold4", 1'b1, 8'hA1, 2'd0);
    chk("bp.count_hold", 32'(out_count), 32'd7);
    step(); in_valid = 3'b000; out_ready = 1'b1; #1;
    out_is("bp.drain0", 1'b1, 8'hA1, 2'd0);
    step(); #1; out_is("bp.drain1", 1'b1, 8'hA2, 2'd0);
    step(); #1; out_is("bp.drain2", 1'b1, 8'hA3, 2'd0);

    // Reset mid-stream: ch1 word in the output register, ch2 word waiting.
    step(); out_ready = 1'b0; in_valid = 3'b110; in_data = {8'h05, 8'h06, 8'h00}; #1;
    out_is("bp.empty", 1'b0, 8'h00, 2'd0);
    chk("bp.count10", 32'(out_count), 32'd10);
    step(); in_valid = 3'b000; #1;
    step(); #1;
    step(); #1; out_is("mid.pre", 1'b1, 8'h06, 2'd1);
    #1; rst_n = 1'b0; #1;
    chk("mid.valid", 32'(out_valid), 32'd0);
    chk("mid.data", 32'(out_data), 32'd0);
    chk("mid.chan", 32'(out_chan), 32'd0);
    chk("mid.count", 32'(out_count), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'h7);
    step();
    step(); rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      out_is($sformatf("mid.idle%0d", c), 1'b0, 8'h00, 2'd0);
    end

    // Accumulate: ch2 0xF0 then 0x20 -> 0xF0, 0x10; ch0 0x20 passes unchanged.
    step(); in_valid = 3'b100; in_data = {8'hF0, 8'h00, 8'h00}; #1;
    step(); in_data = {8'h20, 8'h00, 8'h00}; #1;
    step(); in_valid = 3'b001; in_data = {8'h00, 8'h00, 8'h20}; #1;
    step(); in_valid = 3'b000; #1; out_is("acc.c3", 1'b1, 8'hF0, 2'd2);
    step(); #1; out_is("acc.c4", 1'b1, 8'h10, 2'd2);
    step(); #1; out_is("acc.c5", 1'b1, 8'h20, 2'd0);

    // Counter wrap: 13 more back-to-back transfers bring the 4-bit count to 16 -> 0.
    for (int c = 0; c <= 16; c++) begin
      step();
      if (c <= 12) begin
        in_valid = 3'b001;
        in_data  = {16'h0, 8'hC0 + 8'(c)};
      end else begin
        in_valid = 3'b000;
      end
      #1;
      if (c == 0) begin
        out_is("acc.c6", 1'b0, 8'h00, 2'd0);
        chk("acc.count3", 32'(out_count), 32'd3);
      end
      if (c <= 12) chk($sformatf("wrap.rdy%0d", c), 32'(in_ready[0]), 32'd1);
      if (c >= 3 && c <= 15) begin
        exp_d = 8'hC0 + 8'(c - 3);
        out_is($sformatf("wrap.out%0d", c), 1'b1, exp_d, 2'd0);
      end
      if (c == 15) chk("wrap.count15", 32'(out_count), 32'd15);
      if (c == 16) begin
        out_is("wrap.end", 1'b0, 8'h00, 2'd0);
        chk("wrap.count0", 32'(out_count), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
